// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: single-port word array with fixed access time.
// Latency: LATENCY+1 cycles per access; read data is registered into the final cycle.
// Backpressure: data_ready_mem is low for exactly LATENCY cycles per request, freezing the pipeline.
//
// Ports:
//   clk, rstn             - clock and async active-low reset
//   memread_mem           - load request from EX/MEM
//   memwrite_mem          - store request from EX/MEM
//   alu_result_mem        - byte address; [ADDR_WIDTH+1:2] selects the word, upper bits wrap
//   write_data_memory_mem - store data
//   data_from_memory_mem  - registered load data, valid in the final cycle of an access
//   data_ready_mem        - high lets the pipeline advance
//   misalign_err          - sticky flag for any request with address bits [1:0] nonzero
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_memory_mem,
  output logic [31:0] data_from_memory_mem,
  output logic        data_ready_mem,
  output logic        misalign_err
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    req;
  logic                    final_cyc;
  logic                    load_rd;
  logic                    do_wr;
  logic                    misalign_set;
  logic                    unused_addr_bits;

  assign req              = memread_mem | memwrite_mem;
  assign idx              = alu_result_mem[ADDR_WIDTH+1:2];
  // Address bits above the array wrap; they play no part in the access.
  assign unused_addr_bits = ^alu_result_mem[31:ADDR_WIDTH+2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Mealy ready: a new request in IDLE stalls the pipeline in the same cycle.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    data_ready_mem = 1'b1;
    final_cyc      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          data_ready_mem = 1'b0;
          state_nxt      = BUSY;
          cnt_nxt        = 4'd1;
        end
      end
      BUSY: begin
        if (cnt == LAT) begin
          final_cyc = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          data_ready_mem = 1'b0;
          cnt_nxt        = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Capture read data on the edge that enters the final cycle (covers LATENCY=1,
  // where that edge is the IDLE->BUSY one). The write lands one edge later, so a
  // combined read/write returns the old word.
  assign load_rd      = (state_nxt == BUSY) && (cnt_nxt == LAT);
  assign do_wr        = final_cyc & memwrite_mem;
  assign misalign_set = (state == IDLE) && req && (alu_result_mem[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_from_memory_mem <= 32'd0;
    end else if (load_rd) begin
      data_from_memory_mem <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_err <= 1'b0;
    end else if (misalign_set) begin
      misalign_err <= 1'b1;
    end
  end

  // Array has no reset; a reset mid-access simply never reaches the write edge.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[idx] <= write_data_memory_mem;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level memory model.
// Driver sets expectations per access cycle; one negedge process compares every cycle.
// Literal checks pin ready patterns and returned words.
module tb_dmem_responder;

  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rstn;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_memory_mem;
  logic [31:0] data_from_memory_mem;
  logic        data_ready_mem;
  logic        misalign_err;

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .memread_mem           (memread_mem),
    .memwrite_mem          (memwrite_mem),
    .alu_result_mem        (alu_result_mem),
    .write_data_memory_mem (write_data_memory_mem),
    .data_from_memory_mem  (data_from_memory_mem),
    .data_ready_mem        (data_ready_mem),
    .misalign_err          (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  logic [31:0] model_mem   [DEPTH];
  bit          model_known [DEPTH];
  logic        exp_rdy;
  logic [31:0] exp_data;
  bit          exp_known;
  logic        exp_err;
  bit          chk_en;
  logic [7:0]  rdy_hist;

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'd0, data_ready_mem}, {31'd0, exp_rdy});
      check("misalign", {31'd0, misalign_err}, {31'd0, exp_err});
      if (exp_known) check("rdata", data_from_memory_mem, exp_data);
      rdy_hist = {rdy_hist[6:0], data_ready_mem};
    end
  end

  // One access from the driver's point of view: LAT+1 cycles, ready only in the last.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int idx;
    idx = int'((addr >> 2) % DEPTH);
    memread_mem           = rd;
    memwrite_mem          = wr;
    alu_result_mem        = addr;
    write_data_memory_mem = wdata;
    for (int k = 0; k <= LAT; k++) begin
      exp_rdy = (k == LAT);
      if (k == LAT) begin
        exp_data  = model_mem[idx];
        exp_known = model_known[idx];
      end
      if (k == 1 && addr[1:0] != 2'b00) exp_err = 1'b1;
      @(posedge clk); #1;
    end
    if (wr) begin
      model_mem[idx]   = wdata;
      model_known[idx] = 1'b1;
    end
    memread_mem  = 1'b0;
    memwrite_mem = 1'b0;
  endtask

  task automatic idle(input int n);
    exp_rdy = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rdy_hist = 8'd0;
    for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;
    rstn = 1'b0;
    memread_mem = 1'b0;
    memwrite_mem = 1'b0;
    alu_result_mem = 32'd0;
    write_data_memory_mem = 32'd0;
    exp_rdy = 1'b1;
    exp_data = 32'd0;
    exp_known = 1'b1;
    exp_err = 1'b0;
    chk_en = 1'b1;

    // Reset held with no request
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);

    // Store then load
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    check("store_rdy_pattern", {29'd0, rdy_hist[2:0]}, 32'b001);
    do_access(1'b1, 1'b0, 32'h10, 32'd0);
    check("load_deadbeef", data_from_memory_mem, 32'hDEADBEEF);
    idle(2);

    // Back-to-back loads
    do_access(1'b0, 1'b1, 32'h0, 32'h11);
    do_access(1'b0, 1'b1, 32'h4, 32'h22);
    idle(1);
    do_access(1'b1, 1'b0, 32'h0, 32'd0);
    check("b2b_first", data_from_memory_mem, 32'h11);
    do_access(1'b1, 1'b0, 32'h4, 32'd0);
    check("b2b_second", data_from_memory_mem, 32'h22);
    check("b2b_rdy_pattern", {26'd0, rdy_hist[5:0]}, 32'b001001);
    idle(1);

    // Wrap-around and misalignment
    do_access(1'b0, 1'b1, 32'h1000, 32'h5A);
    do_access(1'b1, 1'b0, 32'h0, 32'd0);
    check("wrap_load", data_from_memory_mem, 32'h5A);
    check("aligned_no_err", {31'd0, misalign_err}, 32'd0);
    do_access(1'b1, 1'b0, 32'h3, 32'd0);
    check("misalign_set", {31'd0, misalign_err}, 32'd1);
    idle(2);

    // Simultaneous read and write
    do_access(1'b0, 1'b1, 32'h20, 32'hAAAA);
    do_access(1'b1, 1'b1, 32'h20, 32'hBBBB);
    check("rw_old_data", data_from_memory_mem, 32'hAAAA);
    do_access(1'b1, 1'b0, 32'h20, 32'd0);
    check("rw_new_data", data_from_memory_mem, 32'hBBBB);
    check("misalign_sticky", {31'd0, misalign_err}, 32'd1);
    idle(1);

    // Reset mid-store: store never commits
    do_access(1'b0, 1'b1, 32'h8, 32'h1);
    memwrite_mem          = 1'b1;
    alu_result_mem        = 32'h8;
    write_data_memory_mem = 32'h2;
    exp_rdy = 1'b0;
    @(posedge clk); #1;
    exp_rdy = 1'b0;
    #5;
    rstn         = 1'b0;
    memwrite_mem = 1'b0;
    exp_rdy      = 1'b1;
    exp_data     = 32'd0;
    exp_known    = 1'b1;
    exp_err      = 1'b0;
    #1;
    check("rst_async_data", data_from_memory_mem, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    do_access(1'b1, 1'b0, 32'h8, 32'd0);
    check("rst_store_discarded", data_from_memory_mem, 32'h1);
    check("rst_rdy_pattern", {29'd0, rdy_hist[2:0]}, 32'b001);
    idle(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the core's MEM-stage interface. It accepts load/store requests from the EX/MEM pipeline register and services them from an internal word-addressed array with a fixed, configurable access latency. While an access is in flight it drives `data_ready_mem` low, which freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Read data is returned on `data_from_memory_mem` for capture by MEM/WB.

## Interface
- `ADDR_WIDTH`, default 10: log2 of the number of 32-bit words in the array.
- `LATENCY`, default 2: number of stall cycles per access. Legal range is 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `memread_mem`  in  1  load request from EX/MEM.
- `memwrite_mem`  in  1  store request from EX/MEM.
- `alu_result_mem`  in  32  byte address.
- `write_data_memory_mem`  in  32  store data.
- `data_from_memory_mem`  out  32  load data, registered.
- `data_ready_mem`  out  1  high means the pipeline may advance; low stalls every pipeline register.
- `misalign_err`  out  1  sticky flag, set when a request has address bits [1:0] nonzero.

## Operation
- **Request:** `req = memread_mem | memwrite_mem`.
  - Request inputs are stable while `data_ready_mem` is low, because the pipeline is frozen.
- **Word index:** `alu_result_mem[ADDR_WIDTH+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo the array size.
  - Bits [1:0] are ignored for the access itself.
  - If bits [1:0] are nonzero, `misalign_err` is set at the edge that ends the request's first cycle and stays set until reset.
- **State machine:** two states, IDLE and BUSY, plus a 4-bit counter `cnt`.
  - **IDLE, `req`=0:** `data_ready_mem`=1 and the state stays IDLE.
  - **IDLE, `req`=1:** `data_ready_mem`=0, combinational Mealy output in the same cycle. At the next edge go to BUSY with `cnt`=1.
  - **BUSY, `cnt`<`LATENCY`:** `data_ready_mem`=0 and `cnt` increments.
  - **BUSY, `cnt`==`LATENCY`:** this is the final cycle. `data_ready_mem`=1. At the next edge, return to IDLE and clear `cnt`.
- **Read data:**
  - `data_from_memory_mem` is loaded with `mem[index]` at the edge that enters the final cycle.
  - Otherwise it holds its previous value.
- **Write:** `mem[index] <= write_data_memory_mem` at the edge that leaves the final cycle, i.e. the same edge on which the pipeline advances.
- **Read and write asserted together:** both are performed. Read data is the old contents (read-before-write).
- **Back-to-back requests:** a request present in IDLE is always new, because the previous one was consumed at the edge that left the final cycle. Consecutive memory instructions each cost `LATENCY` stall cycles; there is no idle bubble between them.
- **Array:** not reset; contents are undefined until written.

## Timing
- **Reset values:**
  - state IDLE, `cnt`=0
  - `data_from_memory_mem`=0
  - `misalign_err`=0
  - `data_ready_mem` evaluates to `~req`; it is 1 with no request present.
- **Access time:** `LATENCY`+1 cycles per access, `data_ready_mem` low for exactly `LATENCY` of them.
  - `LATENCY`=2 gives low, low, high.
  - `LATENCY`=1 gives low, high.
- **Load-to-use:** load data is valid during the final cycle and is captured by MEM/WB at that cycle's closing edge.
- **Reset mid-access (`rstn` low in BUSY):**
  - The state returns to IDLE immediately (asynchronous).
  - The pending write is discarded, so memory is unchanged.
  - `data_from_memory_mem` goes to 0.
- **Request withdrawn in BUSY:** illegal; the pipeline is frozen. The behaviour is don't-care, but the FSM must still return to IDLE after the final cycle.

## Test plan
- **Reset:** hold `rstn`=0 with `req`=0.
  - Required: `data_ready_mem`=1, `data_from_memory_mem`=0, `misalign_err`=0.
- **Store then load, `LATENCY`=2:**
  - Store 0xDEADBEEF to address 0x10. Required: `data_ready_mem` reads 0,0,1 over three cycles.
  - Then load from 0x10. Required: `data_from_memory_mem`=0xDEADBEEF in the third cycle, with `data_ready_mem`=1 in that cycle.
- **Back-to-back loads:**
  - Loads from addresses 0x0 and 0x4, preloaded with 0x11 and 0x22, presented on consecutive instructions.
  - Required: `data_ready_mem` pattern 0,0,1,0,0,1; data 0x11 then 0x22.
- **Wrap-around and misalignment, `ADDR_WIDTH`=10:**
  - Store 0x5A to address 0x1000, then load from address 0x0. Required: the load returns 0x5A.
  - Load from address 0x3. Required: `misalign_err` rises to 1 and stays set.
- **Simultaneous read and write:**
  - Word 0x20 holds 0xAAAA. Assert `memread_mem` and `memwrite_mem` together with data 0xBBBB.
  - Required: the returned data is 0xAAAA; a following load from 0x20 returns 0xBBBB.
- **Reset mid-store:**
  - Word 0x8 holds 0x1. Start a store of 0x2 to 0x8 and pulse `rstn` low in BUSY.
  - Required: the FSM is back in IDLE; a following load from 0x8 returns 0x1.
